// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types and constants for the PS/2 keyboard event decoder
package ps2_kbd_pkg;

  typedef struct packed {
    logic       pause;
    logic       extended;
    logic       released;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } dec_state_t;

  localparam logic [7:0] PS2_E0         = 8'hE0;
  localparam logic [7:0] PS2_E1         = 8'hE1;
  localparam logic [7:0] PS2_F0         = 8'hF0;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP     = 3'd7;

  // Keyboard housekeeping bytes (BAT OK, ACK, resend, overrun) that never become key events
  localparam int N_DISCARD = 5;
  localparam logic [7:0] DISCARD_CODES [N_DISCARD] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  function automatic logic is_discard(input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (c == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_prefix(input logic [7:0] c);
    return (c == PS2_E0) || (c == PS2_E1) || (c == PS2_F0);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
// Head reads 0 while empty; a pop on an empty FIFO is ignored, a push on a full one is dropped unless paired with a pop.
module ps2_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/ps2_kbd_event.sv
// rtl/ps2_kbd_event.sv - folds PS/2 set-2 scan-code prefixes into key events and queues them for the CPU
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated make events.
module ps2_kbd_event
  import ps2_kbd_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic [7:0]       code_i,
  input  logic             strobe_i,
  input  logic             err_i,
  input  logic             rd_i,
  input  logic             clear_i,
  output logic [10:0]      event_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             rx_err_o
);

  dec_state_t state;
  dec_state_t state_n;
  logic [2:0] skip;
  logic [2:0] skip_n;
  logic       emit;
  kbd_event_t emit_evt;
  logic       enq;
  logic       evt_valid;
  kbd_event_t evt_q;
  logic       fifo_full;
  logic       overflow;
  logic       rx_err;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
      skip  <= '0;
    end else if (clear_i) begin
      state <= ST_IDLE;
      skip  <= '0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  // An E0/E1 seen while already extended restarts decoding as if from idle
  always_comb begin
    state_n = state;
    skip_n  = skip;
    if (err_i) begin
      state_n = ST_IDLE;
      skip_n  = '0;
    end else if (strobe_i) begin
      case (state)
        ST_IDLE, ST_EXT: begin
          if (code_i == PS2_E0) begin
            state_n = ST_EXT;
          end else if (code_i == PS2_E1) begin
            state_n = ST_PAUSE;
            skip_n  = PAUSE_SKIP;
          end else if (code_i == PS2_F0) begin
            state_n = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: state_n = ST_IDLE;
        ST_PAUSE: begin
          skip_n = skip - 3'd1;
          if (skip <= 3'd1) begin
            state_n = ST_IDLE;
            skip_n  = '0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_evt = '0;
    if (strobe_i && !err_i) begin
      case (state)
        ST_IDLE: begin
          if (!is_prefix(code_i) && !is_discard(code_i)) begin
            emit     = 1'b1;
            emit_evt = '{pause: 1'b0, extended: 1'b0, released: 1'b0, code: code_i};
          end
        end
        ST_EXT: begin
          if (!is_prefix(code_i)) begin
            emit     = 1'b1;
            emit_evt = '{pause: 1'b0, extended: 1'b1, released: 1'b0, code: code_i};
          end
        end
        ST_BRK: begin
          emit     = 1'b1;
          emit_evt = '{pause: 1'b0, extended: 1'b0, released: 1'b1, code: code_i};
        end
        ST_EXT_BRK: begin
          emit     = 1'b1;
          emit_evt = '{pause: 1'b0, extended: 1'b1, released: 1'b1, code: code_i};
        end
        ST_PAUSE: begin
          if (skip <= 3'd1) begin
            emit     = 1'b1;
            emit_evt = '{pause: 1'b1, extended: 1'b0, released: 1'b0, code: PS2_PAUSE_CODE};
          end
        end
        default: emit = 1'b0;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_valid;
  logic       repeat_make;

  assign repeat_make = emit && !emit_evt.pause && !emit_evt.released && last_valid &&
                       (last_make == {emit_evt.extended, emit_evt.code});
  assign enq = emit & ~repeat_make;

  // The last key pressed is tracked even if its event is later dropped on a full FIFO
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_make  <= '0;
      last_valid <= 1'b0;
    end else if (clear_i || err_i) begin
      last_make  <= '0;
      last_valid <= 1'b0;
    end else if (emit) begin
      if (emit_evt.pause || emit_evt.released) begin
        last_valid <= 1'b0;
      end else begin
        last_make  <= {emit_evt.extended, emit_evt.code};
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign enq = emit;
`endif

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      evt_valid <= 1'b0;
      evt_q     <= '0;
      overflow  <= 1'b0;
      rx_err    <= 1'b0;
    end else if (clear_i) begin
      evt_valid <= 1'b0;
      evt_q     <= '0;
      overflow  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      evt_valid <= enq;
      if (enq) evt_q <= emit_evt;
      if (err_i) rx_err <= 1'b1;
      // A full FIFO always has a head, so a same-cycle pop makes room
      if (evt_valid && fifo_full && !rd_i) overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (11),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .clear   (clear_i),
    .wr      (evt_valid),
    .wr_data (evt_q),
    .rd      (rd_i),
    .rd_data (event_o),
    .count   (count_o),
    .full    (fifo_full),
    .empty   (empty_o)
  );

  assign overflow_o = overflow;
  assign rx_err_o   = rx_err;

endmodule

// File: tb/tb_ps2_kbd_event.sv
// tb/tb_ps2_kbd_event.sv - self-checking bench: directed vector table, corner sequences and randomized model check
module tb_ps2_kbd_event;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  code = '0;
  logic        strobe = 1'b0;
  logic        err = 1'b0;
  logic        rd = 1'b0;
  logic        clear = 1'b0;
  logic [10:0] event_o;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        rx_err;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_kbd_event dut (
    .clk        (clk),
    .reset_n_i  (reset_n),
    .code_i     (code),
    .strobe_i   (strobe),
    .err_i      (err),
    .rd_i       (rd),
    .clear_i    (clear),
    .event_o    (event_o),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow),
    .rx_err_o   (rx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    code = b; strobe = 1'b1; tick(); strobe = 1'b0;
  endtask

  task automatic pulse_err();
    err = 1'b1; tick(); err = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [10:0] exp);
    check(name, 32'(event_o), 32'(exp));
    pop();
  endtask

  // Reference model: prefix flags and a bounded queue, evaluated per byte
  logic [10:0] mq[$];
  bit          m_ovf, m_err, m_ext, m_brk, m_lv;
  int          m_skip;
  logic [8:0]  m_lm;

  function automatic void m_reset();
    mq.delete();
    m_ovf = 0; m_err = 0; m_ext = 0; m_brk = 0; m_skip = 0; m_lv = 0; m_lm = '0;
  endfunction

  function automatic void m_push(input logic [10:0] e);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (e[10] || e[8]) begin
      m_lv = 0;
    end else begin
      if (m_lv && m_lm == {e[9], e[7:0]}) return;
      m_lm = {e[9], e[7:0]};
      m_lv = 1;
    end
`endif
    if (mq.size() >= 16) m_ovf = 1;
    else mq.push_back(e);
  endfunction

  function automatic void m_error();
    m_err = 1; m_ext = 0; m_brk = 0; m_skip = 0; m_lv = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) m_push(11'h477);
      return;
    end
    if (m_brk) begin
      m_push({1'b0, m_ext, 1'b1, b});
      m_ext = 0; m_brk = 0;
      return;
    end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hE1) begin m_ext = 0; m_skip = 7; return; end
    if (!m_ext && (b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) return;
    m_push({1'b0, m_ext, 1'b0, b});
    m_ext = 0;
  endfunction

  task automatic compare_model(input int it);
    string s;
    s = $sformatf("rnd%0d", it);
    check({s, "_count"}, 32'(count), 32'(mq.size()));
    check({s, "_head"}, 32'(event_o), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    check({s, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({s, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({s, "_rxerr"}, 32'(rx_err), 32'(m_err));
  endtask

  typedef struct {
    logic [7:0][7:0]  bytes;
    int               nb;
    logic [3:0][10:0] exp;
    int               ne;
    string            name;
  } vec_t;

  vec_t        vecs[5];
  logic [10:0] exp_q[$];

  initial begin
    vecs[0] = '{bytes: {8'h1C, 8'hF0, 8'h1C, 40'h0}, nb: 3,
                exp: {11'h01C, 11'h11C, 22'h0}, ne: 2, name: "make_break"};
    vecs[1] = '{bytes: {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 24'h0}, nb: 5,
                exp: {11'h275, 11'h375, 22'h0}, ne: 2, name: "ext_arrow"};
    vecs[2] = '{bytes: {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, nb: 8,
                exp: {11'h477, 33'h0}, ne: 1, name: "pause"};
    vecs[3] = '{bytes: {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 24'h0}, nb: 5,
                exp: 44'h0, ne: 0, name: "discard"};
    vecs[4] = '{bytes: {8'hE0, 8'hE0, 8'h75, 8'hE0, 8'hAA, 8'hF0, 8'hFA, 8'h00}, nb: 7,
                exp: {11'h275, 11'h2AA, 11'h1FA, 11'h0}, ne: 3, name: "reprefix"};

    tick();
    check("rst_event", 32'(event_o), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_rxerr", 32'(rx_err), 32'h0);
    reset_n = 1'b1;
    tick();

    // Two cycles from strobe to a visible head
    send(8'h1C);
    check("lat_c1_empty", 32'(empty), 32'h1);
    tick();
    check("lat_c2_empty", 32'(empty), 32'h0);
    check("lat_c2_event", 32'(event_o), 32'h01C);

    for (int v = 0; v < 5; v++) begin
      pulse_clear();
      for (int i = 0; i < vecs[v].nb; i++) send(vecs[v].bytes[7-i]);
      tick(3);
      check({vecs[v].name, "_count"}, 32'(count), 32'(vecs[v].ne));
      for (int i = 0; i < vecs[v].ne; i++)
        pop_check($sformatf("%s_ev%0d", vecs[v].name, i), vecs[v].exp[3-i]);
      check({vecs[v].name, "_empty"}, 32'(empty), 32'h1);
    end

    pulse_clear();
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    tick(3);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_head", 32'(event_o), 32'h010);
    pulse_clear();
    check("clr_count", 32'(count), 32'h0);
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_empty", 32'(empty), 32'h1);

    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
    tick(3);
    check("full_count", 32'(count), 32'd16);
    send(8'h40);
    pop();
    tick(2);
    check("wrpop_full_count", 32'(count), 32'd16);
    check("wrpop_full_ovf", 32'(overflow), 32'h0);
    check("wrpop_full_head", 32'(event_o), 32'h021);

    pulse_clear();
    send(8'h41);
    pop();
    tick(2);
    check("wrpop_empty_count", 32'(count), 32'd1);
    check("wrpop_empty_head", 32'(event_o), 32'h041);

    pulse_clear();
    send(8'hE0);
    pulse_err();
    send(8'h1C);
    tick(3);
    check("err_flag", 32'(rx_err), 32'h1);
    check("err_event", 32'(event_o), 32'h01C);
    check("err_count", 32'(count), 32'd1);
    code = 8'h2A; strobe = 1'b1; err = 1'b1;
    tick();
    strobe = 1'b0; err = 1'b0;
    tick(3);
    check("strobe_err_drop", 32'(count), 32'd1);

    pulse_clear();
    send(8'hE0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(8'h75);
    tick(3);
    check("rst_prefix_event", 32'(event_o), 32'h075);
    check("rst_prefix_count", 32'(count), 32'd1);

    pulse_clear();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    tick(3);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q = '{11'h01C, 11'h11C, 11'h01C};
`else
    exp_q = '{11'h01C, 11'h01C, 11'h01C, 11'h11C, 11'h01C};
`endif
    check("typ_count", 32'(count), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) pop_check($sformatf("typ_ev%0d", i), exp_q[i]);

    pulse_clear();
    m_reset();
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 64) begin
        logic [7:0] b;
        int k;
        k = $urandom_range(0, 9);
        case (k)
          0: b = 8'hE0;
          1: b = 8'hF0;
          2: b = 8'hE1;
          3: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFF;
          default: b = 8'($urandom_range(0, 255));
        endcase
        if ($urandom_range(0, 99) < 3) begin
          m_error();
          code = b; strobe = 1'b1; err = 1'b1;
          tick();
          strobe = 1'b0; err = 1'b0;
        end else begin
          m_byte(b);
          send(b);
        end
      end else if (r < 67) begin
        m_error();
        pulse_err();
      end else if (r < 87) begin
        if (mq.size() > 0) void'(mq.pop_front());
        pop();
      end else if (r == 99) begin
        m_reset();
        pulse_clear();
      end else begin
        tick();
      end
      tick(2);
      compare_model(it);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
